vram_arb: RTL

VRAM_ARB -- requirements
Module: vram_arb

---
 rtl/vram_arb_if.sv | 56 +++++
 rtl/vram_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vram_arb_if.sv
// Bus bundle for the VRAM arbiter: video scan-out, register port, blitter port
// and the single-port VRAM command/return path.
interface vram_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              vid_sel_i;
  logic [ADDR_W-1:0] vid_addr_i;
  logic [DATA_W-1:0] vid_data_o;

  logic              regs_req_i;
  logic              regs_wr_i;
  logic [ADDR_W-1:0] regs_addr_i;
  logic [DATA_W-1:0] regs_data_i;
  logic              regs_ack_o;
  logic              regs_rd_valid_o;
  logic [DATA_W-1:0] regs_data_o;

  logic              blit_req_i;
  logic              blit_wr_i;
  logic [ADDR_W-1:0] blit_addr_i;
  logic [DATA_W-1:0] blit_data_i;
  logic              blit_ack_o;
  logic              blit_rd_valid_o;
  logic [DATA_W-1:0] blit_data_o;

  logic              vram_sel_o;
  logic              vram_wr_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_data_o;
  logic [DATA_W-1:0] vram_data_i;

  // Arbiter side.
  modport slave (
    input  vid_sel_i, vid_addr_i,
    input  regs_req_i, regs_wr_i, regs_addr_i, regs_data_i,
    input  blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
    input  vram_data_i,
    output vid_data_o,
    output regs_ack_o, regs_rd_valid_o, regs_data_o,
    output blit_ack_o, blit_rd_valid_o, blit_data_o,
    output vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o
  );

  // Requester / memory side.
  modport master (
    output vid_sel_i, vid_addr_i,
    output regs_req_i, regs_wr_i, regs_addr_i, regs_data_i,
    output blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
    output vram_data_i,
    input  vid_data_o,
    input  regs_ack_o, regs_rd_valid_o, regs_data_o,
    input  blit_ack_o, blit_rd_valid_o, blit_data_o,
    input  vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o
  );
endinterface

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: video reads have absolute priority, regs and blit
// share the remaining cycles round-robin; read data returns two cycles after issue.
module vram_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic       clk,
  input logic       reset_n_i,
  vram_arb_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_REGS, OWN_BLIT} owner_e;
  typedef enum logic {RR_REGS, RR_BLIT} rr_e;

  rr_e               rr_q, rr_d;
  owner_e            issue_d;
  owner_e            tag0_q, tag0_d;
  owner_e            tag1_q, tag1_d;
  logic              regs_elig, blit_elig;

  logic              sel_q, sel_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regs_ack_q, regs_ack_d;
  logic              blit_ack_q, blit_ack_d;

  logic              regs_rv_q, regs_rv_d;
  logic              blit_rv_q, blit_rv_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [DATA_W-1:0] regs_data_q, regs_data_d;
  logic [DATA_W-1:0] blit_data_q, blit_data_d;

  // A port acked this cycle is still holding req; it must not win the next edge.
  assign regs_elig = bus.regs_req_i && !regs_ack_q;
  assign blit_elig = bus.blit_req_i && !blit_ack_q;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rr_d    = rr_q;
    issue_d = OWN_NONE;
    if (bus.vid_sel_i) begin
      issue_d = OWN_VID;
    end else if (regs_elig && (!blit_elig || rr_q == RR_REGS)) begin
      issue_d = OWN_REGS;
      rr_d    = RR_BLIT;
    end else if (blit_elig) begin
      issue_d = OWN_BLIT;
      rr_d    = RR_REGS;
    end
  end

  always_comb begin
    sel_d      = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    regs_ack_d = 1'b0;
    blit_ack_d = 1'b0;
    unique case (issue_d)
      OWN_VID: begin
        sel_d  = 1'b1;
        addr_d = bus.vid_addr_i;
      end
      OWN_REGS: begin
        sel_d      = 1'b1;
        wr_d       = bus.regs_wr_i;
        addr_d     = bus.regs_addr_i;
        regs_ack_d = 1'b1;
        if (bus.regs_wr_i) wdata_d = bus.regs_data_i;
      end
      OWN_BLIT: begin
        sel_d      = 1'b1;
        wr_d       = bus.blit_wr_i;
        addr_d     = bus.blit_addr_i;
        blit_ack_d = 1'b1;
        if (bus.blit_wr_i) wdata_d = bus.blit_data_i;
      end
      default: ;
    endcase
  end

  // tag0 names the owner of the read being issued, tag1 the owner of the read
  // whose data is on vram_data_i right now; writes carry no tag.
  assign tag0_d = wr_d ? OWN_NONE : issue_d;
  assign tag1_d = tag0_q;

  always_comb begin
    vid_data_d  = vid_data_q;
    regs_data_d = regs_data_q;
    blit_data_d = blit_data_q;
    regs_rv_d   = 1'b0;
    blit_rv_d   = 1'b0;
    unique case (tag1_q)
      OWN_VID:  vid_data_d = bus.vram_data_i;
      OWN_REGS: begin
        regs_data_d = bus.vram_data_i;
        regs_rv_d   = 1'b1;
      end
      OWN_BLIT: begin
        blit_data_d = bus.vram_data_i;
        blit_rv_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      rr_q        <= RR_REGS;
      tag0_q      <= OWN_NONE;
      tag1_q      <= OWN_NONE;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      regs_ack_q  <= 1'b0;
      blit_ack_q  <= 1'b0;
      regs_rv_q   <= 1'b0;
      blit_rv_q   <= 1'b0;
      // NOTE: the read-data holding registers are reset as well, because every
      // output must read 0 in the cycle after reset.
      vid_data_q  <= '0;
      regs_data_q <= '0;
      blit_data_q <= '0;
    end else begin
      rr_q        <= rr_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      regs_ack_q  <= regs_ack_d;
      blit_ack_q  <= blit_ack_d;
      regs_rv_q   <= regs_rv_d;
      blit_rv_q   <= blit_rv_d;
      vid_data_q  <= vid_data_d;
      regs_data_q <= regs_data_d;
      blit_data_q <= blit_data_d;
    end
  end

  assign bus.vram_sel_o      = sel_q;
  assign bus.vram_wr_o       = wr_q;
  assign bus.vram_addr_o     = addr_q;
  assign bus.vram_data_o     = wdata_q;
  assign bus.regs_ack_o      = regs_ack_q;
  assign bus.blit_ack_o      = blit_ack_q;
  assign bus.regs_rd_valid_o = regs_rv_q;
  assign bus.blit_rd_valid_o = blit_rv_q;
  assign bus.vid_data_o      = vid_data_q;
  assign bus.regs_data_o     = regs_data_q;
  assign bus.blit_data_o     = blit_data_q;

endmodule
